rom_loader: RTL and testbench

//   Instruction store and serial boot loader directly upstream of the HACK computer.

---
 rtl/rom_loader.sv | 202 ++++++++++++++++++++
 tb/tb_rom_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// rom_loader: instruction store and serial boot loader for the HACK CPU.
// Receives LEN (16b, high byte first) followed by LEN 16-bit words (high byte
// first), writes them into a 2^ADDR_W x 16 memory, then releases cpu_reset.
// In RUN the memory serves inst combinationally for the CPU's pc.
// Optional feature: define CHECKSUM_EN to require a trailing 16-bit checksum
// (sum mod 2^16 of all data words) before entering RUN.
module rom_loader #(
   parameter int ADDR_W = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic [14:0] pc,
   output logic [15:0] inst,
   output logic        cpu_reset,
   input  logic        reload,
   output logic        busy,
   output logic        error,
   output logic [15:0] words_loaded
);

`ifdef CHECKSUM_EN
   typedef enum logic [2:0] {
      LEN_HI  = 3'd0,
      LEN_LO  = 3'd1,
      DATA_HI = 3'd2,
      DATA_LO = 3'd3,
      CSUM_HI = 3'd4,
      CSUM_LO = 3'd5,
      RUN     = 3'd6,
      ERR     = 3'd7
   } state_t;
`else
   typedef enum logic [2:0] {
      LEN_HI  = 3'd0,
      LEN_LO  = 3'd1,
      DATA_HI = 3'd2,
      DATA_LO = 3'd3,
      RUN     = 3'd6,
      ERR     = 3'd7
   } state_t;
`endif

   // Largest accepted program length: exactly fills the memory.
   localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state;
   logic [7:0]        byte_hi;
   logic [15:0]       len;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       rx_word;
   logic              xfer;
   logic [15:0]       mem [0:(1<<ADDR_W)-1];
`ifdef CHECKSUM_EN
   logic [15:0]       csum;
`endif

   assign xfer    = rx_valid & rx_ready;
   assign rx_word = {byte_hi, rx_data};

   // Loader FSM: state, counters and the registered handshake/status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= LEN_HI;
         rx_ready     <= 1'b1;
         cpu_reset    <= 1'b1;
         busy         <= 1'b1;
         error        <= 1'b0;
         words_loaded <= 16'd0;
         wr_addr      <= '0;
         len          <= 16'd0;
         byte_hi      <= 8'd0;
`ifdef CHECKSUM_EN
         csum         <= 16'd0;
`endif
      end else begin
         case (state)
            LEN_HI: begin
               if (xfer) begin
                  byte_hi <= rx_data;
                  state   <= LEN_LO;
               end
            end
            LEN_LO: begin
               if (xfer) begin
                  len <= rx_word;
                  if (rx_word == 16'd0) begin
`ifdef CHECKSUM_EN
                     // An empty program still carries a (zero) checksum.
                     state <= CSUM_HI;
`else
                     state     <= RUN;
                     rx_ready  <= 1'b0;
                     busy      <= 1'b0;
                     cpu_reset <= 1'b0;
`endif
                  end else if ({1'b0, rx_word} > MAX_LEN) begin
                     state    <= ERR;
                     rx_ready <= 1'b0;
                     busy     <= 1'b0;
                     error    <= 1'b1;
                  end else begin
                     state <= DATA_HI;
                  end
               end
            end
            DATA_HI: begin
               if (xfer) begin
                  byte_hi <= rx_data;
                  state   <= DATA_LO;
               end
            end
            DATA_LO: begin
               if (xfer) begin
                  // wr_addr never needs to wrap: LEN was bounded to the depth.
                  wr_addr      <= wr_addr + ADDR_ONE;
                  words_loaded <= words_loaded + 16'd1;
`ifdef CHECKSUM_EN
                  csum         <= csum + rx_word;
`endif
                  if ((words_loaded + 16'd1) == len) begin
`ifdef CHECKSUM_EN
                     state <= CSUM_HI;
`else
                     state     <= RUN;
                     rx_ready  <= 1'b0;
                     busy      <= 1'b0;
                     cpu_reset <= 1'b0;
`endif
                  end else begin
                     state <= DATA_HI;
                  end
               end
            end
`ifdef CHECKSUM_EN
            CSUM_HI: begin
               if (xfer) begin
                  byte_hi <= rx_data;
                  state   <= CSUM_LO;
               end
            end
            CSUM_LO: begin
               if (xfer) begin
                  rx_ready <= 1'b0;
                  busy     <= 1'b0;
                  if (rx_word == csum) begin
                     state     <= RUN;
                     cpu_reset <= 1'b0;
                  end else begin
                     // Written words stay in memory; CPU is held in reset.
                     state <= ERR;
                     error <= 1'b1;
                  end
               end
            end
`endif
            RUN, ERR: begin
               if (reload) begin
                  state        <= LEN_HI;
                  rx_ready     <= 1'b1;
                  busy         <= 1'b1;
                  cpu_reset    <= 1'b1;
                  error        <= 1'b0;
                  words_loaded <= 16'd0;
                  wr_addr      <= '0;
`ifdef CHECKSUM_EN
                  csum         <= 16'd0;
`endif
               end
            end
            default: begin
               // Unreachable encoding: park safely with the CPU held in reset.
               state     <= ERR;
               rx_ready  <= 1'b0;
               busy      <= 1'b0;
               cpu_reset <= 1'b1;
               error     <= 1'b1;
            end
         endcase
      end
   end

   // Instruction memory write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if ((state == DATA_LO) && xfer) begin
         mem[wr_addr] <= rx_word;
      end
   end

   // Combinational fetch for the CPU; zero whenever the program is not running.
   always_comb begin
      if (state == RUN) begin
         inst = mem[pc[ADDR_W-1:0]];
      end else begin
         inst = 16'h0000;
      end
   end

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: byte-position reference model plus
// directed streams with hand-computed literal expectations.
module tb_rom_loader;

   localparam int ADDR_W = 15;
`ifdef CHECKSUM_EN
   localparam bit CS = 1'b1;
`else
   localparam bit CS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [14:0] pc = 15'd0;
   logic [15:0] inst;
   logic        cpu_reset;
   logic        reload = 1'b0;
   logic        busy;
   logic        error;
   logic [15:0] words_loaded;

   int checks = 0;
   int errors = 0;

   rom_loader #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .pc(pc), .inst(inst), .cpu_reset(cpu_reset),
      .reload(reload), .busy(busy), .error(error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // mode: 0 = loading, 1 = running, 2 = error. pos counts accepted bytes.
   int          m_mode = 0;
   int          m_pos = 0;
   int          m_len = 0;
   int          m_words = 0;
   logic [7:0]  m_hi = 8'd0;
   logic [15:0] m_sum = 16'd0;
   logic [15:0] m_mem [0:(1<<ADDR_W)-1];
   bit          m_wr  [0:(1<<ADDR_W)-1];

   task automatic m_clear();
      m_mode = 0; m_pos = 0; m_words = 0; m_sum = 16'd0;
   endtask

   task automatic m_accept(input logic [7:0] b);
      logic [15:0] w;
      if (m_pos == 0) begin
         m_hi = b;
      end else if (m_pos == 1) begin
         m_len = int'({m_hi, b});
         if (m_len > (1 << ADDR_W)) m_mode = 2;
         else if (m_len == 0 && !CS) m_mode = 1;
      end else if (m_pos < 2 + 2 * m_len) begin
         if ((m_pos % 2) == 0) begin
            m_hi = b;
         end else begin
            w = {m_hi, b};
            m_mem[m_words] = w;
            m_wr[m_words] = 1'b1;
            m_words++;
            m_sum = m_sum + w;
            if (m_words == m_len && !CS) m_mode = 1;
         end
      end else if (m_pos == 2 + 2 * m_len) begin
         m_hi = b;
      end else begin
         m_mode = ({m_hi, b} == m_sum) ? 1 : 2;
      end
      m_pos++;
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) m_clear();
         else if (m_mode == 0 && rx_valid) m_accept(rx_data);
         else if (m_mode != 0 && reload) m_clear();
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      chk("rx_ready", rx_ready, (m_mode == 0));
      chk("busy", busy, (m_mode == 0));
      chk("cpu_reset", cpu_reset, (m_mode != 1));
      chk("error", error, (m_mode == 2));
      chk("words_loaded", words_loaded, m_words);
      if (m_mode != 1) chk("inst_idle", inst, 32'h0);
      else if (m_wr[pc]) chk("inst_run", inst, m_mem[pc]);
   end

   // ---------------- stimulus ----------------
   logic [7:0] t1 [0:7] = '{8'h00, 8'h03, 8'h00, 8'h01, 8'hEC, 8'h10, 8'hE3, 8'h08};

   task automatic send_byte(input logic [7:0] b, input int idle);
      int n;
      n = 0;
      rx_data = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 20) begin
         @(posedge clk); #2;
         n++;
      end
      if (!rx_ready) chk("rx_ready_wait", rx_ready, 32'h1);
      @(posedge clk); #2;
      rx_valid = 1'b0;
      repeat (idle) begin
         @(posedge clk); #2;
      end
   endtask

   task automatic send_test1(input int idle, input logic [7:0] csum_lo);
      for (int i = 0; i < 8; i++) send_byte(t1[i], idle);
      if (CS) begin
         send_byte(8'hCF, idle);
         send_byte(csum_lo, idle);
      end
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(posedge clk); #2;
      reload = 1'b0;
   endtask

   task automatic check_prog1(input string tag);
      pc = 15'd0; #1; chk({tag, "_inst0"}, inst, 32'h0001);
      pc = 15'd1; #1; chk({tag, "_inst1"}, inst, 32'hEC10);
      pc = 15'd2; #1; chk({tag, "_inst2"}, inst, 32'hE308);
      chk({tag, "_words"}, words_loaded, 32'd3);
      chk({tag, "_cpu_reset"}, cpu_reset, 32'h0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      chk("rst_rx_ready", rx_ready, 32'h1);
      chk("rst_busy", busy, 32'h1);
      chk("rst_cpu_reset", cpu_reset, 32'h1);
      chk("rst_error", error, 32'h0);
      chk("rst_words", words_loaded, 32'h0);
      chk("rst_inst", inst, 32'h0);

      // Test 1: basic 3-word program; RUN in the cycle after the last byte.
      send_test1(0, 8'h19);
      check_prog1("t1");

      // Test 2: empty program.
      pulse_reload();
      chk("t2_reload_cpu_reset", cpu_reset, 32'h1);
      chk("t2_reload_words", words_loaded, 32'h0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      if (CS) begin
         send_byte(8'h00, 0);
         send_byte(8'h00, 0);
      end
      chk("t2_cpu_reset", cpu_reset, 32'h0);
      chk("t2_words", words_loaded, 32'h0);
      chk("t2_rx_ready", rx_ready, 32'h0);

      // Test 3: oversize LEN, then recovery via reload.
      pulse_reload();
      send_byte(8'h80, 0);
      send_byte(8'h01, 0);
      chk("t3_error", error, 32'h1);
      chk("t3_cpu_reset", cpu_reset, 32'h1);
      chk("t3_rx_ready", rx_ready, 32'h0);
      pulse_reload();
      chk("t3_reload_error", error, 32'h0);
      chk("t3_reload_rx_ready", rx_ready, 32'h1);

      // Test 4: idle gaps between bytes, pc parked on loaded data; a stray
      // reload during loading must be ignored.
      pc = 15'd1;
      send_byte(t1[0], 3);
      pulse_reload();
      for (int i = 1; i < 8; i++) send_byte(t1[i], 3);
      if (CS) begin
         send_byte(8'hCF, 3);
         send_byte(8'h19, 0);
      end
      check_prog1("t4");

      // Test 5: reset mid-load, then a fresh full load.
      pulse_reload();
      for (int i = 0; i < 5; i++) send_byte(t1[i], 0);
      chk("t5_mid_words", words_loaded, 32'd1);
      reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      chk("t5_words", words_loaded, 32'h0);
      chk("t5_busy", busy, 32'h1);
      send_test1(0, 8'h19);
      check_prog1("t5");

      // Test 6: wrong checksum lands in ERR with the CPU held.
      if (CS) begin
         pulse_reload();
         send_test1(0, 8'h18);
         chk("t6_error", error, 32'h1);
         chk("t6_cpu_reset", cpu_reset, 32'h1);
         chk("t6_words", words_loaded, 32'd3);
      end

      repeat (2) @(posedge clk);
      #6;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
